// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the packet FIFO write arbiter.
//
// Contents:
//   arb_state_e        arbiter FSM states (IDLE, XFER)
//   src_idx_t          source index type sized for the default source count
//   DEFAULT_*          default parameter values used by fifo_wr_arbiter
package fifo_arb_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_NUM_SRC   = 4;
    localparam int DEFAULT_MAX_BEATS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    typedef logic [$clog2(DEFAULT_NUM_SRC)-1:0] src_idx_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//
// Searches req starting at ptr+1 (mod N) and returns the first asserted
// index. found is low when req is all zero (idx is then 0).
//
// Ports:
//   req    in   N           request vector
//   ptr    in   $clog2(N)   last granted index; search starts one above it
//   found  out  1           some request is asserted
//   idx    out  $clog2(N)   chosen index
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk offsets from the farthest to the nearest so that the nearest
    // asserted request (lowest offset above ptr) is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-atomic write arbiter sharing one
// packet FIFO between NUM_SRC sources. A grant is held from a packet's first
// beat up to and including the beat carrying req_last, so packets never
// interleave in the FIFO.
//
// Optional feature macro: PKT_LEN_LIMIT_EN. When defined, packets longer
// than MAX_BEATS are cut after beat MAX_BEATS, len_err pulses for one cycle
// and the source's remaining beats compete as a new packet. When undefined,
// packets are unbounded and len_err is tied low.
//
// Handshake: a beat moves on a cycle where req_valid[g] and req_ready[g] are
// both high for the granted source g; req_ready[g] is !fifo_full_flag during
// XFER, so fifo_wr_en is exactly that accept condition and a stalled source
// must hold its data.
//
// Ports:
//   clk             in   1              rising-edge clock
//   rst             in   1              asynchronous active-high reset
//   req_valid       in   NUM_SRC        per-source beat valid
//   req_data        in   NUM_SRC*WIDTH  source i at [i*WIDTH +: WIDTH]
//   req_last        in   NUM_SRC        per-source last-beat marker
//   req_ready       out  NUM_SRC        per-source beat accepted
//   fifo_wdata      out  WIDTH          FIFO write data (pass-through)
//   fifo_wr_en      out  1              FIFO write enable
//   fifo_full_flag  in   1              FIFO full
//   grant_id        out  $clog2(NUM_SRC) currently granted source
//   busy            out  1              packet in progress (state == XFER)
//   len_err         out  1              one-cycle truncation pulse
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int NUM_SRC   = DEFAULT_NUM_SRC,
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         req_valid,
    input  logic [NUM_SRC*WIDTH-1:0]   req_data,
    input  logic [NUM_SRC-1:0]         req_last,
    output logic [NUM_SRC-1:0]         req_ready,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full_flag,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       len_err
);

    localparam int IW = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 16 || MAX_BEATS < 1) begin : g_param_check
        $error("fifo_wr_arbiter: NUM_SRC must be 2..16 and MAX_BEATS >= 1");
    end

    arb_state_e    state;
    logic [IW-1:0] rr_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          beat_acc;

    rr_pick #(.N(NUM_SRC)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy       = (state == XFER);
    assign fifo_wdata = req_data[grant_id*WIDTH +: WIDTH];
    assign fifo_wr_en = busy & req_valid[grant_id] & !fifo_full_flag;
    assign beat_acc   = fifo_wr_en;

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[grant_id] = !fifo_full_flag;
        end
    end

`ifdef PKT_LEN_LIMIT_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [CW-1:0] beat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IW'(NUM_SRC - 1);
            grant_id <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc) begin
                        if (req_last[grant_id]) begin
                            rr_ptr <= grant_id;
                            state  <= IDLE;
                        end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
                            // Beat MAX_BEATS without last: cut the packet;
                            // the rest re-arbitrates as a fresh packet.
                            rr_ptr  <= grant_id;
                            len_err <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign len_err = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= IW'(NUM_SRC - 1);
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc && req_last[grant_id]) begin
                        rr_ptr <= grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Each source replays a small table of beats and advances
// only on cycles where it saw req_valid & req_ready.
module tb_fifo_wr_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     fifo_wdata;
    logic             fifo_wr_en;
    logic             fifo_full_flag = 1'b0;
    logic [1:0]       grant_id;
    logic             busy;
    logic             len_err;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_SRC(N), .MAX_BEATS(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_wdata     (fifo_wdata),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_full_flag (fifo_full_flag),
        .grant_id       (grant_id),
        .busy           (busy),
        .len_err        (len_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int tests = 0;
    int fails = 0;

    logic [W:0]   src_mem [N][16];   // {last, data}
    int           src_len [N];
    int           src_pos [N];
    logic [N-1:0] hold = '0;
    logic         full = 1'b0;

    logic [W-1:0] exp_q[$];          // expected FIFO words in order
    logic [W-1:0] exp_gnt[$];        // expected grant sequence

    logic         prev_busy = 1'b0;
    int           len_err_cnt = 0;

    logic         s_busy, s_wr_en, s_len_err;
    logic [1:0]   s_grant;
    logic [W-1:0] s_wdata;
    logic [N-1:0] s_ready, s_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic add_beat(input int s, input logic [W-1:0] d, input logic last);
        src_mem[s][src_len[s]] = {last, d};
        src_len[s]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = (src_pos[i] < src_len[i]) && !hold[i];
            req_valid[i]         = v;
            req_data[i*W +: W]   = v ? src_mem[i][src_pos[i]][W-1:0] : '0;
            req_last[i]          = v & src_mem[i][src_pos[i]][W];
        end
        fifo_full_flag = full;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        hold = '0;
        full = 1'b0;
    endtask

    // One clock: sample at the falling edge, then advance sources after the
    // rising edge on which their beat was taken.
    task automatic cycle();
        #4;
        s_busy    = busy;
        s_wr_en   = fifo_wr_en;
        s_wdata   = fifo_wdata;
        s_grant   = grant_id;
        s_ready   = req_ready;
        s_len_err = len_err;
        s_acc     = req_valid & req_ready;
        check("no_wr_when_full", {31'd0, fifo_wr_en & fifo_full_flag}, 32'd0);
        if (fifo_wr_en) begin
            check("wr_expected_present", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("fifo_word", fifo_wdata, exp_q.pop_front());
        end
        if (busy && !prev_busy) begin
            check("gnt_expected_present", {31'd0, exp_gnt.size() != 0}, 32'd1);
            if (exp_gnt.size() != 0) check("grant_order", {30'd0, grant_id}, exp_gnt.pop_front());
        end
        prev_busy = busy;
        if (len_err) len_err_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_acc[i]) src_pos[i]++;
        end
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            cycle();
            n++;
            done = !s_busy;
            for (int i = 0; i < N; i++) begin
                if (src_pos[i] < src_len[i]) done = 1'b0;
            end
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    // Called just after a rising edge; checks the asynchronous reset values.
    task automatic do_reset();
        rst = 1'b1;
        clear_sources();
        drive();
        #1;
        check("rst_ready",   {28'd0, req_ready}, 32'd0);
        check("rst_wr_en",   {31'd0, fifo_wr_en}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_grant",   {30'd0, grant_id}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        prev_busy = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_sources();
        @(posedge clk);
        #1;
        do_reset();

        // 1: source 2 sends A0,A1,A2
        add_beat(2, 32'hA0, 1'b0);
        add_beat(2, 32'hA1, 1'b0);
        add_beat(2, 32'hA2, 1'b1);
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1); exp_q.push_back(32'hA2);
        exp_gnt.push_back(32'd2);
        drive();
        cycle();
        check("s1_arb_busy",  {31'd0, s_busy}, 32'd0);
        check("s1_arb_wr_en", {31'd0, s_wr_en}, 32'd0);
        check("s1_arb_ready", {28'd0, s_ready}, 32'd0);
        cycle();
        check("s1_grant", {30'd0, s_grant}, 32'd2);
        check("s1_beat0", s_wdata, 32'hA0);
        check("s1_ready", {28'd0, s_ready}, 32'b0100);
        cycle();
        check("s1_beat1", s_wdata, 32'hA1);
        cycle();
        check("s1_beat2", s_wdata, 32'hA2);
        check("s1_wr_en", {31'd0, s_wr_en}, 32'd1);
        cycle();
        check("s1_busy_drop", {31'd0, s_busy}, 32'd0);

        // 2: all four sources, two 2-beat packets each; fresh reset so 0 is first
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int p = 0; p < 2; p++) begin
                add_beat(i, 32'hB000 + 32'(i*16 + p*2), 1'b0);
                add_beat(i, 32'hB001 + 32'(i*16 + p*2), 1'b1);
            end
        end
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                exp_gnt.push_back(32'(i));
                exp_q.push_back(32'hB000 + 32'(i*16 + p*2));
                exp_q.push_back(32'hB001 + 32'(i*16 + p*2));
            end
        end
        drive();
        run_until_idle("s2_drain", 80);

        // 3: source 1 stalled by FIFO full for 5 cycles after its first beat
        add_beat(1, 32'hC0, 1'b0);
        add_beat(1, 32'hC1, 1'b0);
        add_beat(1, 32'hC2, 1'b0);
        add_beat(1, 32'hC3, 1'b1);
        exp_q.push_back(32'hC0); exp_q.push_back(32'hC1);
        exp_q.push_back(32'hC2); exp_q.push_back(32'hC3);
        exp_gnt.push_back(32'd1);
        drive();
        cycle();
        cycle();
        check("s3_beat0", s_wdata, 32'hC0);
        full = 1'b1;
        drive();
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("s3_full_wr_en", {31'd0, s_wr_en}, 32'd0);
            check("s3_full_ready", {28'd0, s_ready}, 32'd0);
            check("s3_full_grant", {30'd0, s_grant}, 32'd1);
        end
        full = 1'b0;
        drive();
        cycle();
        check("s3_release_wr_en", {31'd0, s_wr_en}, 32'd1);
        check("s3_release_word", s_wdata, 32'hC1);
        run_until_idle("s3_drain", 20);

        // 4: source 0 bubbles for 3 cycles while source 3 waits
        add_beat(0, 32'hD0, 1'b0);
        add_beat(0, 32'hD1, 1'b0);
        add_beat(0, 32'hD2, 1'b0);
        add_beat(0, 32'hD3, 1'b1);
        exp_q.push_back(32'hD0); exp_q.push_back(32'hD1);
        exp_q.push_back(32'hD2); exp_q.push_back(32'hD3);
        exp_q.push_back(32'hE0); exp_q.push_back(32'hE1);
        exp_gnt.push_back(32'd0);
        exp_gnt.push_back(32'd3);
        drive();
        cycle();
        add_beat(3, 32'hE0, 1'b0);
        add_beat(3, 32'hE1, 1'b1);
        drive();
        cycle();
        check("s4_beat0", s_wdata, 32'hD0);
        cycle();
        check("s4_beat1", s_wdata, 32'hD1);
        hold[0] = 1'b1;
        drive();
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("s4_bubble_grant", {30'd0, s_grant}, 32'd0);
            check("s4_bubble_wr_en", {31'd0, s_wr_en}, 32'd0);
            check("s4_bubble_busy",  {31'd0, s_busy}, 32'd1);
        end
        hold[0] = 1'b0;
        drive();
        cycle();
        check("s4_beat2", s_wdata, 32'hD2);
        cycle();
        check("s4_beat3", s_wdata, 32'hD3);
        run_until_idle("s4_drain", 20);

        // 5: reset during beat 2 of a 4-beat packet from source 3
        add_beat(3, 32'hF0, 1'b0);
        add_beat(3, 32'hF1, 1'b0);
        add_beat(3, 32'hF2, 1'b0);
        add_beat(3, 32'hF3, 1'b1);
        exp_q.push_back(32'hF0);
        exp_gnt.push_back(32'd3);
        drive();
        cycle();
        cycle();
        check("s5_beat0", s_wdata, 32'hF0);
        do_reset();
        add_beat(0, 32'h60, 1'b0);
        add_beat(0, 32'h61, 1'b1);
        add_beat(3, 32'h70, 1'b1);
        exp_q.push_back(32'h60); exp_q.push_back(32'h61); exp_q.push_back(32'h70);
        exp_gnt.push_back(32'd0);
        exp_gnt.push_back(32'd3);
        drive();
        run_until_idle("s5_drain", 20);

        // 6: source 1 sends a 6-beat packet
        len_err_cnt = 0;
        for (int b = 0; b < 6; b++) begin
            add_beat(1, 32'h90 + 32'(b), (b == 5) ? 1'b1 : 1'b0);
            exp_q.push_back(32'h90 + 32'(b));
        end
        exp_gnt.push_back(32'd1);
`ifdef PKT_LEN_LIMIT_EN
        exp_gnt.push_back(32'd1);
`endif
        drive();
        for (int c = 0; c < 6; c++) cycle();
`ifdef PKT_LEN_LIMIT_EN
        check("s6_cut_len_err", {31'd0, s_len_err}, 32'd1);
        check("s6_cut_busy",    {31'd0, s_busy}, 32'd0);
        run_until_idle("s6_drain", 20);
        check("s6_len_err_cnt", 32'(len_err_cnt), 32'd1);
`else
        check("s6_beat4_wr_en", {31'd0, s_wr_en}, 32'd1);
        check("s6_beat4_word",  s_wdata, 32'h94);
        run_until_idle("s6_drain", 20);
        check("s6_len_err_cnt", 32'(len_err_cnt), 32'd0);
`endif

        check("exp_q_empty",   32'(exp_q.size()), 32'd0);
        check("exp_gnt_empty", 32'(exp_gnt.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-atomic write arbiter that shares the single packet FIFO between NUM_SRC packet sources.
- A grant is held for a whole packet, from its first beat to the beat carrying req_last, so packets never interleave in the FIFO.
- Sits between the parser front-end lanes and the FIFO write port (wdata / wr_en / full_flag).

Parameters:
- WIDTH, 32, data word width; matches the FIFO WIDTH.
- NUM_SRC, 4, number of requesting sources; range 2..16.
- MAX_BEATS, 64, maximum beats per packet; used only when PKT_LEN_LIMIT_EN is defined.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_SRC  per-source beat valid.
- req_data  input  NUM_SRC*WIDTH  flattened per-source data; source i occupies bits [i*WIDTH +: WIDTH].
- req_last  input  NUM_SRC  per-source last-beat marker.
- req_ready  output  NUM_SRC  per-source beat accepted.
- fifo_wdata  output  WIDTH  to FIFO wdata.
- fifo_wr_en  output  1  to FIFO wr_en.
- fifo_full_flag  input  1  from FIFO full_flag.
- grant_id  output  $clog2(NUM_SRC)  currently granted source.
- busy  output  1  a packet is in progress.
- len_err  output  1  one-cycle pulse when a packet is truncated (PKT_LEN_LIMIT_EN only; tied 0 otherwise).

Behaviour:
- Reset values (asynchronous, immediate):
  - State IDLE; rr_ptr = NUM_SRC-1, so source 0 has first priority.
  - grant_id = 0; busy = 0.
  - req_ready = 0, fifo_wr_en = 0, len_err = 0.
  - Beat counter = 0.
- States: IDLE, XFER.
- IDLE:
  - Search req_valid starting at rr_ptr+1 (mod NUM_SRC) and take the first asserted source g.
  - If one is found: register grant_id <= g and go to XFER.
  - No beat is accepted in IDLE; req_ready = 0. Arbitration latency is 1 cycle.
  - If no req_valid is asserted, stay in IDLE.
- XFER:
  - req_ready[grant_id] = !fifo_full_flag; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full_flag.
  - fifo_wdata = req_data[grant_id], combinational pass-through with zero added latency.
  - A beat is accepted when req_valid & req_ready of the granted source are both high.
  - Accepted beat with req_last: rr_ptr <= grant_id, go to IDLE. The next packet therefore starts at the earliest 2 cycles later.
- busy = (state == XFER).
- FIFO full:
  - The beat stalls; source data must be held.
  - The grant is kept and no timeout applies.
- Requests and grants:
  - Non-granted sources are never accepted.
  - A granted source dropping req_valid mid-packet creates a bubble; the grant is kept.
- Fairness: with all sources continuously requesting, grants rotate 0,1,2,3,0,...
- Reset mid-packet: the packet is abandoned, the FIFO is not touched by this block, and it returns to IDLE with source 0 first.
- fifo_wr_en is never asserted while fifo_full_flag = 1.

Optional Feature:
- Macro: PKT_LEN_LIMIT_EN.
- Defined:
  - The beat counter increments per accepted beat and clears on entry to XFER.
  - If beat MAX_BEATS is accepted without req_last, the arbiter forces a return to IDLE, pulses len_err for one cycle, and sets rr_ptr <= grant_id.
  - The source's remaining beats compete as a new packet.
- Undefined: no counter; len_err is tied to 0; packets are unbounded.

Decomposition:
- Package fifo_arb_pkg holds:
  - the arb_state_e enum {IDLE, XFER};
  - the src_idx_t typedef sized $clog2(NUM_SRC) at the default;
  - the localparam DEFAULT_MAX_BEATS.
- Sub-module rr_pick, combinational: inputs req vector and rr_ptr; outputs found and idx.
  - Instantiated once; unit-testable on its own.

Test Plan:
- Reset then source 2 sends 3 beats 0xA0,0xA1,0xA2 (last on 0xA2) -> grant_id=2 after 1 cycle; FIFO receives A0,A1,A2 on consecutive cycles; busy drops after the last beat.
- Sources 0..3 all request 2-beat packets continuously -> grant order 0,1,2,3,0; no interleaved words in the FIFO readback.
- Source 1 mid-packet with fifo_full_flag forced high for 5 cycles -> fifo_wr_en=0 and req_ready[1]=0 for 5 cycles; the held word is written once the flag is released; no duplicates.
- Source 0 drops req_valid for 3 cycles mid-packet while source 3 requests -> grant stays 0; source 3 is granted only after source 0's last beat.
- Assert rst during beat 2 of a 4-beat packet from source 3 -> all outputs 0 immediately; after release, requests from 0 and 3 together -> source 0 granted first.
- PKT_LEN_LIMIT_EN with MAX_BEATS=4, source 1 sends 6 beats -> 4 beats written, len_err pulses once, source 1 re-granted for the remaining 2 beats (if no other requester).
